// File: rtl/cache_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_pkg
// Purpose  : Shared types and geometry helpers for the cache line-fill arbiter
// Revision : 1.0  initial release
// ============================================================================
package cache_fill_pkg;

  // Default geometry: two channels (I-cache, D-cache), 16-bit words, 8-word lines
  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_WORDS_PER_LINE = 8;

  // Fill controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes per memory word
  function automatic int word_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits covered by one cache line
  function automatic int line_off_w(input int words, input int data_w);
    return $clog2(words * (data_w / 8));
  endfunction

  // Width of the word index within a line
  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

  localparam int WORD_BYTES = word_bytes(DEF_DATA_W);
  localparam int LINE_OFF_W = line_off_w(DEF_WORDS_PER_LINE, DEF_DATA_W);
  localparam int IDX_W      = idx_w(DEF_WORDS_PER_LINE);

endpackage
`default_nettype wire

// File: rtl/cache_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_arbiter_if
// Purpose  : Cache-miss / memory / fill bundle for the line-fill arbiter.
//            master = caches + memory side, slave = the arbiter itself.
// Revision : 1.0  initial release
// ============================================================================
interface cache_fill_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic [NUM_CH-1:0]        miss_req;
  logic [NUM_CH*ADDR_W-1:0] miss_addr;
  logic                     mem_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data_in;
  logic                     mem_data_valid;
  logic                     fill_we;
  logic [NUM_CH-1:0]        fill_ch;
  logic [IDX_W-1:0]         fill_word_idx;
  logic [DATA_W-1:0]        fill_data;
  logic [NUM_CH-1:0]        fill_done;
  logic                     busy;

  modport master (
    output miss_req, miss_addr, mem_data_in, mem_data_valid,
    input  mem_en, mem_addr, fill_we, fill_ch, fill_word_idx, fill_data,
           fill_done, busy
  );

  modport slave (
    input  miss_req, miss_addr, mem_data_in, mem_data_valid,
    output mem_en, mem_addr, fill_we, fill_ch, fill_word_idx, fill_data,
           fill_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter; grants the first requester at or after the
//            pointer, pointer moves past the winner when advance is asserted.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N    = 2,
  localparam int c_iw = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [N-1:0]    i_req,
  input  wire logic            i_adv,
  output logic      [N-1:0]    o_gnt,
  output logic      [c_iw-1:0] o_gnt_idx
);

  logic [c_iw-1:0] r_ptr;

  // Scan requesters circularly starting at the pointer; first hit wins
  always_comb begin
    int  w_idx;
    logic w_found;
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && 1'(i_req >> w_idx)) begin
        w_found   = 1'b1;
        o_gnt     = N'(1) << w_idx;
        o_gnt_idx = c_iw'(w_idx);
      end
    end
  end

  // Pointer moves to the channel after the winner so it gets lowest priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv && (|i_req)) begin
      r_ptr <= (int'(o_gnt_idx) == N - 1) ? '0 : o_gnt_idx + c_iw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_arbiter
// Purpose  : Line-fill controller shared by several cache miss channels.
//            Grants one miss round-robin, issues one word read per cycle for
//            the whole line, streams returns into the owning cache and pulses
//            that channel's fill_done when the line is complete.
// Revision : 1.0  initial release
// ============================================================================
module cache_fill_arbiter
  import cache_fill_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input wire logic           clk,
  input wire logic           rst,
  cache_fill_arbiter_if.slave bus
);

  localparam int c_word_bytes = word_bytes(DATA_W);
  localparam int c_line_off_w = line_off_w(WORDS_PER_LINE, DATA_W);
  localparam int c_idx_w      = idx_w(WORDS_PER_LINE);
  localparam int c_ch_w       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_idx_w-1:0] c_last      = c_idx_w'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0]  c_line_mask = {ADDR_W{1'b1}} << c_line_off_w;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_owner;
  logic [ADDR_W-1:0]   r_base;
  logic [c_idx_w-1:0]  r_issue_cnt;
  logic [c_idx_w-1:0]  r_ret_cnt;
  logic [NUM_CH-1:0]   w_gnt;
  logic [c_ch_w-1:0]   w_gnt_idx;
  logic [ADDR_W-1:0]   w_req_addr;
  logic                w_adv;
  logic                w_fill_we;
  logic                w_ret_last;
  logic                w_issue_last;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.miss_req),
    .i_adv     (w_adv),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Address of the granted channel, picked out of the packed request bus
  assign w_req_addr = ADDR_W'(bus.miss_addr >> (int'(w_gnt_idx) * ADDR_W));

  // Returns are only accepted while a fill owns the memory port
  assign w_fill_we    = bus.mem_data_valid && ((r_state == ISSUE) || (r_state == DRAIN));
  assign w_ret_last   = w_fill_we && (r_ret_cnt == c_last);
  assign w_issue_last = (r_state == ISSUE) && (r_issue_cnt == c_last);

  // Next-state decode and all outputs, derived from the current state
  always_comb begin
    w_state_nxt        = r_state;
    w_adv              = 1'b0;
    bus.mem_en         = 1'b0;
    bus.mem_addr       = '0;
    bus.fill_we        = w_fill_we;
    bus.fill_word_idx  = w_fill_we ? r_ret_cnt : '0;
    bus.fill_data      = w_fill_we ? bus.mem_data_in : '0;
    bus.fill_ch        = (r_state != IDLE) ? r_owner : '0;
    bus.fill_done      = (r_state == DONE) ? r_owner : '0;
    bus.busy           = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (|bus.miss_req) begin
          w_state_nxt = ISSUE;
          w_adv       = 1'b1;
        end
      end
      ISSUE: begin
        bus.mem_en   = 1'b1;
        // base has the line offset cleared, so this add never leaves the line
        bus.mem_addr = r_base + ADDR_W'(r_issue_cnt) * ADDR_W'(c_word_bytes);
        if (w_issue_last) w_state_nxt = w_ret_last ? DONE : DRAIN;
      end
      DRAIN: begin
        if (w_ret_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, owner/base capture at grant, issue and return counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv) begin
        r_owner     <= w_gnt;
        r_base      <= w_req_addr & c_line_mask;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
      end else begin
        if (r_state == ISSUE) r_issue_cnt <= r_issue_cnt + c_idx_w'(1);
        if (w_fill_we)        r_ret_cnt   <= r_ret_cnt + c_idx_w'(1);
      end
    end
  end

endmodule
`default_nettype wire
